// File: rtl/rr_pkg.sv
// Shared types and helpers for the round-robin request collector.
package rr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GRANT = 2'd2
  } rr_state_t;

  localparam int unsigned REQCNT_DEF  = 5;
  localparam int unsigned MAXPEND_DEF = 3;

  // Binary client number to one-hot vector; callers slice to REQCNT bits.
  function automatic logic [31:0] onehot(input logic [31:0] num);
    return 32'd1 << num;
  endfunction

endpackage

// File: rtl/rr_pend_cnt.sv
// Per-client saturating pending-request counter with overflow flag.
module rr_pend_cnt #(
  parameter int unsigned MAXPEND = 3,
  parameter int unsigned CNTW    = $clog2(MAXPEND + 1)
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic nonzero_o,
  output logic ovf_o
);

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            full, nonzero;

  always_comb begin
    full    = (cnt_q == CNTW'(MAXPEND));
    nonzero = (cnt_q != '0);
    cnt_d   = cnt_q;
    ovf_o   = 1'b0;
    // A simultaneous inc and dec cancel, even when full.
    if (inc_i && !dec_i) begin
      if (full) ovf_o = 1'b1;
      else      cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i && nonzero) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign full_o    = full;
  assign nonzero_o = nonzero;

endmodule

// File: rtl/rr_req_collector.sv
// Client-side front end of the round-robin arbiter: pending counters, issue, grant.
// Optional grant timeout enabled by defining RR_GNT_TIMEOUT_EN.
module rr_req_collector
  import rr_pkg::*;
#(
  parameter int unsigned REQCNT   = REQCNT_DEF,
  parameter int unsigned REQWIDTH = $clog2(REQCNT),
  parameter int unsigned MAXPEND  = MAXPEND_DEF,
  parameter int unsigned CNTW     = $clog2(MAXPEND + 1),
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [REQCNT-1:0]   req_stb_i,
  output logic [REQCNT-1:0]   req_rdy_o,
  output logic [REQCNT-1:0]   req_o,
  output logic                req_val_o,
  input  logic [REQWIDTH-1:0] req_num_i,
  output logic [REQCNT-1:0]   gnt_o,
  output logic [REQWIDTH-1:0] gnt_num_o,
  input  logic                gnt_ack_i,
  output logic                err_o,
  output logic                timeout_o
);

  // Handshake: req_val_o is high for exactly one cycle per arbitration and
  // req_num_i is sampled on that edge; gnt_o is held until gnt_ack_i is seen.

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("rr_req_collector: TIMEOUT must be 2 or more");
  end

  rr_state_t           state_q, state_d;
  logic [REQWIDTH-1:0] num_q, num_d;
  logic                err_q, err_d;
  logic [REQCNT-1:0]   dec, full, nonzero, ovf;
  logic [REQCNT-1:0]   gnt_vec;
  logic [31:0]         oh_full;
  logic                sel_nz;

`ifdef RR_GNT_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmr_q, tmr_d;
  logic          tmo_q, tmo_d;
`endif

  for (genvar g = 0; g < REQCNT; g++) begin : g_cnt
    rr_pend_cnt #(
      .MAXPEND (MAXPEND),
      .CNTW    (CNTW)
    ) u_cnt (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .inc_i     (req_stb_i[g]),
      .dec_i     (dec[g]),
      .full_o    (full[g]),
      .nonzero_o (nonzero[g]),
      .ovf_o     (ovf[g])
    );
  end

  // Out-of-range numbers match no client and therefore read as "not pending".
  always_comb begin
    sel_nz = 1'b0;
    for (int k = 0; k < REQCNT; k++) begin
      if (req_num_i == REQWIDTH'(k)) sel_nz = nonzero[k];
    end
  end

  always_comb begin
    oh_full = onehot(32'(num_q));
    gnt_vec = oh_full[REQCNT-1:0];
  end

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    err_d   = err_q | (|ovf);
    dec     = '0;
`ifdef RR_GNT_TIMEOUT_EN
    tmo_d   = 1'b0;
    tmr_d   = (state_q == GRANT) ? tmr_q + 1'b1 : '0;
`endif
    case (state_q)
      IDLE: begin
        if (|nonzero) state_d = ISSUE;
      end
      ISSUE: begin
        if (sel_nz) begin
          num_d   = req_num_i;
          state_d = GRANT;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (gnt_ack_i) begin
          dec     = gnt_vec;
          state_d = IDLE;
        end
`ifdef RR_GNT_TIMEOUT_EN
        else if (tmr_q == TW'(TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      num_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      err_q   <= err_d;
    end
  end

`ifdef RR_GNT_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      tmr_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      tmo_q <= tmo_d;
    end
  end
  assign timeout_o = tmo_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign req_rdy_o = ~full;
  assign req_o     = nonzero;
  assign req_val_o = (state_q == ISSUE);
  assign gnt_o     = (state_q == GRANT) ? gnt_vec : '0;
  assign gnt_num_o = num_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_rr_req_collector.sv
// Directed bench for rr_req_collector with a round-robin arbiter model and grant scoreboard.
module tb_rr_req_collector;

  localparam int REQCNT   = 5;
  localparam int REQWIDTH = 3;
  localparam int MAXPEND  = 3;
  localparam int TIMEOUT  = 4;

  logic                clk_i = 1'b0;
  logic                rst_n_i;
  logic [REQCNT-1:0]   req_stb_i;
  logic [REQCNT-1:0]   req_rdy_o;
  logic [REQCNT-1:0]   req_o;
  logic                req_val_o;
  logic [REQWIDTH-1:0] req_num_i;
  logic [REQCNT-1:0]   gnt_o;
  logic [REQWIDTH-1:0] gnt_num_o;
  logic                gnt_ack_i;
  logic                err_o;
  logic                timeout_o;

  logic [REQWIDTH-1:0] exp_q[$];
  int n_checks = 0;
  int n_errs   = 0;
  int val_pulses = 0;

  // Arbiter model with an override for injecting bad numbers
  int                  ptr;
  int                  arb_num;
  logic                force_en;
  logic [REQWIDTH-1:0] force_num;

  rr_req_collector #(
    .REQCNT   (REQCNT),
    .REQWIDTH (REQWIDTH),
    .MAXPEND  (MAXPEND),
    .CNTW     (2),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .req_stb_i (req_stb_i),
    .req_rdy_o (req_rdy_o),
    .req_o     (req_o),
    .req_val_o (req_val_o),
    .req_num_i (req_num_i),
    .gnt_o     (gnt_o),
    .gnt_num_o (gnt_num_o),
    .gnt_ack_i (gnt_ack_i),
    .err_o     (err_o),
    .timeout_o (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  always_comb begin
    int idx;
    logic found;
    arb_num = 0;
    found   = 1'b0;
    for (int i = 0; i < REQCNT; i++) begin
      idx = (ptr + i) % REQCNT;
      if (!found && req_o[idx]) begin
        arb_num = idx;
        found   = 1'b1;
      end
    end
  end

  assign req_num_i = force_en ? force_num : REQWIDTH'(arb_num);

  always @(posedge clk_i) begin
    if (!rst_n_i) ptr <= 0;
    else if (req_val_o && int'(req_num_i) < REQCNT) ptr <= (int'(req_num_i) + 1) % REQCNT;
  end

  always @(negedge clk_i) begin
    if (req_val_o === 1'b1) val_pulses <= val_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_n_i   = 1'b0;
    req_stb_i = '1;
    gnt_ack_i = 1'b0;
    force_en  = 1'b0;
    repeat (2) tick();
  endtask

  task automatic release_reset();
    rst_n_i   = 1'b1;
    req_stb_i = '0;
    tick();
  endtask

  task automatic strobe(input logic [REQCNT-1:0] mask);
    req_stb_i = mask;
    tick();
    req_stb_i = '0;
  endtask

  task automatic await_grant();
    int waited;
    logic [REQWIDTH-1:0] exp_num;
    waited = 0;
    while (gnt_o == '0 && waited < 40) begin
      tick();
      waited++;
    end
    check("grant_seen", 32'(gnt_o != '0), 32'd1);
    check("exp_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      exp_num = exp_q.pop_front();
      check("gnt_num", 32'(gnt_num_o), 32'(exp_num));
      check("gnt_onehot", 32'(gnt_o), 32'd1 << exp_num);
    end
  endtask

  task automatic ack_grant(input logic [REQCNT-1:0] stb);
    gnt_ack_i = 1'b1;
    req_stb_i = stb;
    tick();
    gnt_ack_i = 1'b0;
    req_stb_i = '0;
    check("gnt_drop", 32'(gnt_o), 32'd0);
  endtask

  task automatic bad_issue(input logic [REQWIDTH-1:0] num);
    do_reset();
    release_reset();
    check("err_after_reset", 32'(err_o), 32'd0);
    force_en  = 1'b1;
    force_num = num;
    strobe(5'b00001);
    tick();
    check("bad_issue_val", 32'(req_val_o), 32'd1);
    tick();
    force_en = 1'b0;
    check("bad_issue_err", 32'(err_o), 32'd1);
    check("bad_issue_nogrant", 32'(gnt_o), 32'd0);
    exp_q.push_back(3'd0);
    await_grant();
    ack_grant('0);
    check("bad_issue_err_sticky", 32'(err_o), 32'd1);
  endtask

  initial begin
    int v0;
    req_stb_i = '0;
    gnt_ack_i = 1'b0;
    force_en  = 1'b0;
    force_num = '0;
    rst_n_i   = 1'b0;

    // Reset with strobes active
    do_reset();
    check("rst_gnt", 32'(gnt_o), 32'd0);
    check("rst_gnt_num", 32'(gnt_num_o), 32'd0);
    check("rst_val", 32'(req_val_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_tmo", 32'(timeout_o), 32'd0);
    check("rst_req", 32'(req_o), 32'd0);
    check("rst_rdy", 32'(req_rdy_o), 32'h1f);
    release_reset();
    check("rel_val0", 32'(req_val_o), 32'd0);
    tick();
    check("rel_val1", 32'(req_val_o), 32'd0);
    check("rel_req", 32'(req_o), 32'd0);

    // Single request on client 2 with exact timing
    exp_q.push_back(3'd2);
    strobe(5'b00100);
    check("single_req", 32'(req_o), 32'h04);
    check("single_val_early", 32'(req_val_o), 32'd0);
    tick();
    check("single_val", 32'(req_val_o), 32'd1);
    tick();
    check("single_val_off", 32'(req_val_o), 32'd0);
    await_grant();
    ack_grant('0);
    check("single_req_clear", 32'(req_o), 32'd0);
    check("single_num_hold", 32'(gnt_num_o), 32'd2);

    // Round-robin closure over clients 0,1,3
    do_reset();
    release_reset();
    v0 = val_pulses;
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd3);
    strobe(5'b01011);
    repeat (3) begin
      await_grant();
      ack_grant('0);
    end
    repeat (4) tick();
    check("rr_val_pulses", 32'(val_pulses - v0), 32'd3);
    check("rr_req_clear", 32'(req_o), 32'd0);

    // Saturation on client 4
    check("sat_err_before", 32'(err_o), 32'd0);
    v0 = val_pulses;
    req_stb_i = 5'b10000;
    repeat (3) tick();
    check("sat_rdy", 32'(req_rdy_o[4]), 32'd0);
    check("sat_err_not_yet", 32'(err_o), 32'd0);
    tick();
    req_stb_i = '0;
    check("sat_err", 32'(err_o), 32'd1);
    repeat (3) exp_q.push_back(3'd4);
    repeat (3) begin
      await_grant();
      ack_grant('0);
    end
    repeat (8) tick();
    check("sat_grants", 32'(val_pulses - v0), 32'd3);
    check("sat_req_clear", 32'(req_o), 32'd0);
    check("sat_err_sticky", 32'(err_o), 32'd1);

    // Bad selected numbers: out of range, and a client with nothing pending
    bad_issue(3'd6);
    bad_issue(3'd2);

    // Strobe and retire on client 1 in the same cycle
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd1);
    strobe(5'b00010);
    await_grant();
    ack_grant(5'b00010);
    check("same_cycle_req", 32'(req_o[1]), 32'd1);
    await_grant();
    ack_grant('0);
    check("same_cycle_clear", 32'(req_o), 32'd0);

    // Long grant without ack
    exp_q.push_back(3'd3);
    strobe(5'b01000);
    await_grant();
`ifdef RR_GNT_TIMEOUT_EN
    repeat (3) tick();
    check("tmo_hold_gnt", 32'(gnt_o), 32'h08);
    check("tmo_not_yet", 32'(timeout_o), 32'd0);
    tick();
    check("tmo_gnt_drop", 32'(gnt_o), 32'd0);
    check("tmo_pulse", 32'(timeout_o), 32'd1);
    check("tmo_cnt_kept", 32'(req_o), 32'h08);
    tick();
    check("tmo_pulse_end", 32'(timeout_o), 32'd0);
    exp_q.push_back(3'd3);
    await_grant();
    repeat (3) tick();
    ack_grant('0);
    check("tmo_ack_wins", 32'(timeout_o), 32'd0);
    check("tmo_req_clear", 32'(req_o), 32'd0);
`else
    repeat (20) tick();
    check("hold_gnt", 32'(gnt_o), 32'h08);
    check("hold_no_tmo", 32'(timeout_o), 32'd0);
    ack_grant('0);
    check("hold_req_clear", 32'(req_o), 32'd0);
`endif

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
